// File: rtl/ddu_run_ctrl.sv
// Run/step sequencer and memory-view address controller for the debug display unit.
// Conditions front-panel inputs, drives the CPU clock enable and handles address auto-repeat.
module ddu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 2500000,
    parameter int REPEAT_RATE     = 500000,
    parameter int ADDR_W          = 8
) (
    input  logic              clk_5M,
    input  logic              reset,
    input  logic              cont,
    input  logic              step,
    input  logic              inc,
    input  logic              dec,
    input  logic              halt_req,
    output logic              cpu_en,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       cyc_cnt,
    output logic [1:0]        state_o
);

    // state | meaning
    // PAUSE | CPU frozen, waiting for run switch or step press
    // RUN   | CPU free-running
    // STEP  | single enabled cycle, then back to PAUSE
    // HALT  | program finished; released by falling edge of cont
    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [3:0] raw, sync1, sync2, lvl, lvl_d;
    assign raw = {dec, inc, step, cont};

    always_ff @(posedge clk_5M or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_d <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_d <= lvl;
        end
    end

    // Debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            lvl_q;

        always_ff @(posedge clk_5M or posedge reset) begin
            if (reset) begin
                cnt   <= '0;
                lvl_q <= 1'b0;
            end else if (sync2[i] == lvl_q) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt   <= '0;
                lvl_q <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign lvl[i] = lvl_q;
    end

    logic cont_db, cont_fall, step_p, inc_db, dec_db, inc_p, dec_p;
    assign cont_db   = lvl[0];
    assign cont_fall = ~lvl[0] & lvl_d[0];
    assign step_p    = lvl[1] & ~lvl_d[1];
    assign inc_db    = lvl[2];
    assign inc_p     = lvl[2] & ~lvl_d[2];
    assign dec_db    = lvl[3];
    assign dec_p     = lvl[3] & ~lvl_d[3];

    state_t state, state_nxt;
    logic   cpu_en_nxt;

    always_ff @(posedge clk_5M or posedge reset) begin
        if (reset) begin
            state   <= PAUSE;
            cpu_en  <= 1'b0;
            cyc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            cpu_en <= cpu_en_nxt;
            if (cpu_en) cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PAUSE: begin
                if (halt_req)     state_nxt = HALT;
                else if (cont_db) state_nxt = RUN;
                else if (step_p)  state_nxt = STEP;
            end
            RUN: begin
                if (halt_req)      state_nxt = HALT;
                else if (!cont_db) state_nxt = PAUSE;
            end
            STEP:    state_nxt = halt_req ? HALT : PAUSE;
            HALT:    if (cont_fall) state_nxt = PAUSE;
            default: state_nxt = PAUSE;
        endcase
    end

    // cpu_en is registered from the next state so it tracks the state register exactly.
    always_comb begin
        cpu_en_nxt = (state_nxt == RUN) || (state_nxt == STEP);
        state_o    = state;
    end

    logic [RPT_W-1:0] rep_cnt;
    logic             rep_first;

    always_ff @(posedge clk_5M or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if ((inc_db && dec_db) || (inc_p && dec_p)) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (inc_p || dec_p) begin
            addr      <= inc_p ? addr + 1'b1 : addr - 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (inc_db ^ dec_db) begin
            if (rep_cnt == (rep_first ? DELAY_LAST : RATE_LAST)) begin
                addr      <= inc_db ? addr + 1'b1 : addr - 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end else begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end
    end

endmodule
